// File: rtl/fifo_reader.sv
// fifo_reader: pops words from a first-word-fall-through FIFO into a 2-entry
// skid buffer and presents them on a valid/ready stream; supports flush.
//   clk, rst          clock, synchronous active-high reset
//   Dout, pndng, pop  FIFO read port (head word, non-empty, pop strobe)
//   enable            permits normal pops
//   flush, flush_done flush request / one-cycle completion pulse
//   out_data, out_valid, out_ready  downstream stream
//   word_count, drop_count  statistics, built only with FIFO_READER_STATS_EN
module fifo_reader #(
   parameter int width = 16,
   parameter int cnt_w = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [width-1:0] Dout,
   input  logic             pndng,
   output logic             pop,
   input  logic             enable,
   input  logic             flush,
   output logic             flush_done,
   output logic [width-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [cnt_w-1:0] word_count,
   output logic [cnt_w-1:0] drop_count
);
   typedef enum logic {RUN, FLUSH} state_e;
   state_e state_q, state_d;
   logic [1:0] occ_q, occ_d, wpos;
   logic [width-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
   logic done_q, done_d, rd, wr;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         occ_q   <= '0;
         buf0_q  <= '0;
         buf1_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         buf0_q  <= buf0_d;
         buf1_q  <= buf1_d;
         done_q  <= done_d;
      end
   end
   always_comb begin
      state_d = state_q == RUN ? (flush ? FLUSH : RUN) : (pndng ? FLUSH : RUN);
      done_d  = state_q == FLUSH && !pndng;
   end
   always_comb begin
      out_valid  = state_q == RUN && occ_q != 2'd0;
      pop        = !rst && (state_q == RUN ? pndng && enable && occ_q != 2'd2 : pndng);
      out_data   = buf0_q;
      flush_done = done_q;
   end
   // The tail slot is computed after the head is removed, so a simultaneous
   // read and write keeps FIFO order and the head stays put under backpressure.
   always_comb begin
      rd     = out_valid && out_ready;
      wr     = pop && state_q == RUN;
      wpos   = occ_q - {1'b0, rd};
      occ_d  = state_q == RUN && !flush ? occ_q + {1'b0, wr} - {1'b0, rd} : 2'd0;
      buf0_d = wr && wpos == 2'd0 ? Dout : (rd ? buf1_q : buf0_q);
      buf1_d = wr && wpos == 2'd1 ? Dout : buf1_q;
   end
`ifdef FIFO_READER_STATS_EN
   logic [cnt_w-1:0] wc_q, dc_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         wc_q <= '0;
         dc_q <= '0;
      end else begin
         if (rd) wc_q <= wc_q + 1'b1;
         if (pop && state_q == FLUSH) dc_q <= dc_q + 1'b1;
      end
   end
   assign word_count = wc_q;
   assign drop_count = dc_q;
`else
   assign word_count = '0;
   assign drop_count = '0;
`endif
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed and random stimulus against a queue-based model.
module tb_fifo_reader;
   localparam int W = 16, CW = 32;
   logic clk = 1'b0;
   logic rst, pndng, pop, enable, flush, flush_done, out_valid, out_ready;
   logic [W-1:0] Dout, out_data;
   logic [CW-1:0] word_count, drop_count;
   always #5 clk = ~clk;
   fifo_reader #(.width(W), .cnt_w(CW)) dut (
      .clk(clk), .rst(rst), .Dout(Dout), .pndng(pndng), .pop(pop),
      .enable(enable), .flush(flush), .flush_done(flush_done),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .word_count(word_count), .drop_count(drop_count)
   );
   logic [W-1:0] fq[$], mb[$];
   bit m_flush, m_done, m_zero;
   int unsigned words, drops;
   int checks, errs;
   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic push(int n, logic [W-1:0] base);
      for (int i = 0; i < n; i++) fq.push_back(base + W'(i));
   endtask
   task automatic cyc(bit r, bit en, bit fl, bit rdy, bit do_chk = 1'b1);
      bit ep, ev;
      rst = r; enable = en; flush = fl; out_ready = rdy;
      pndng = fq.size() != 0;
      Dout = pndng ? fq[0] : '0;
      #1;
      ep = !r && (m_flush ? pndng : (pndng && en && mb.size() < 2));
      ev = !m_flush && mb.size() != 0;
      if (do_chk) begin
         chk("pop", pop, ep);
         chk("out_valid", out_valid, ev);
         if (ev) chk("out_data", out_data, mb[0]);
         else if (m_zero) chk("out_data_rst", out_data, 0);
         chk("flush_done", flush_done, m_done);
`ifdef FIFO_READER_STATS_EN
         chk("word_count", word_count, words);
         chk("drop_count", drop_count, drops);
`else
         chk("word_count", word_count, 0);
         chk("drop_count", drop_count, 0);
`endif
      end
      @(posedge clk);
      if (r) begin
         mb.delete(); m_flush = 0; m_done = 0; m_zero = 1; words = 0; drops = 0;
      end else if (!m_flush) begin
         if (ev && rdy) begin void'(mb.pop_front()); words++; end
         if (ep) begin mb.push_back(Dout); m_zero = 0; end
         m_done = 0;
         if (fl) begin mb.delete(); m_flush = 1; end
      end else begin
         if (ep) drops++;
         m_done = !pndng;
         m_flush = pndng;
      end
      if (ep) void'(fq.pop_front());
      #1;
   endtask
   initial begin
      checks = 0; errs = 0; words = 0; drops = 0;
      m_flush = 0; m_done = 0; m_zero = 0;
      // reset held 3 cycles with the FIFO non-empty
      fq.push_back(16'h00A5);
      cyc(1, 1, 0, 1, 0);
      cyc(1, 1, 0, 1);
      cyc(1, 1, 0, 1);
      repeat (3) cyc(0, 1, 0, 1);
      // streaming
      push(8, 16'h0001);
      repeat (11) cyc(0, 1, 0, 1);
      // backpressure then release
      push(8, 16'h0010);
      repeat (6) cyc(0, 1, 0, 0);
      repeat (12) cyc(0, 1, 0, 1);
      // enable gating
      push(4, 16'h0020);
      repeat (3) cyc(0, 0, 0, 1);
      repeat (7) cyc(0, 1, 0, 1);
      // flush with 2 buffered and 6 pending
      push(8, 16'h0030);
      repeat (4) cyc(0, 1, 0, 0);
      cyc(0, 1, 1, 0);
      repeat (9) cyc(0, 1, 0, 0);
      fq.push_back(16'hBEEF);
      repeat (4) cyc(0, 1, 0, 1);
      // flush with FIFO already empty
      cyc(0, 1, 1, 1);
      repeat (4) cyc(0, 1, 0, 1);
      // random traffic
      repeat (400) begin
         if ($urandom_range(0, 2) == 0 && fq.size() < 12) fq.push_back(16'($urandom));
         cyc(0, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
      end
      // reset mid-operation
      push(3, 16'h0040);
      repeat (2) cyc(0, 1, 0, 0);
      cyc(1, 1, 0, 0);
      repeat (6) cyc(0, 1, 0, 1);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
